// File: rtl/sram_like_resp_pkg.sv
// Shared constants for the SRAM-like data responder: access sizes, queue entry widths, stall LFSR.
package sram_like_resp_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int DATA_W = 32;
  localparam int AGE_W  = 3;

  // x^8 + x^6 + x^5 + x^4 + 1, shifted left with feedback into bit 0
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue; every entry carries an age counter so queued entries mature in parallel.
module sram_like_resp_fifo
  import sram_like_resp_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       push_is_wr_i,
  input  logic [DATA_W-1:0]          push_data_i,
  output logic                       head_ready_o,
  output logic                       head_is_wr_o,
  output logic [DATA_W-1:0]          head_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [AGE_W-1:0] AGE_SAT = LATENCY[AGE_W-1:0];
  localparam logic [AGE_W:0]   AGE_LAT = LATENCY[AGE_W:0];

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [AGE_W-1:0]  age_q   [DEPTH];
  logic              is_wr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (wr_ptr_q == ptr_t'(i))) age_q[i] <= '0;
        else if (age_q[i] < AGE_SAT)           age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // NOTE: payload storage is deliberately left out of reset; count_q alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      is_wr_q[wr_ptr_q] <= push_is_wr_i;
      data_q[wr_ptr_q]  <= push_data_i;
    end
  end

  // Ready one cycle early because the response register adds the final cycle.
  assign head_ready_o = (count_q != '0) && (({1'b0, age_q[rd_ptr_q]} + 1'b1) >= AGE_LAT);
  assign head_is_wr_o = is_wr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like data responder: word RAM, addr_ok accept, fixed-latency in-order data_ok responses.
// Optional accept-stall injection when SRAM_RESP_STALL_EN is defined.
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [DATA_W-1:0]     mem [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept, stall;
  logic                  head_ready, head_is_wr;
  logic [DATA_W-1:0]     head_data;
  logic [CNT_W-1:0]      count;
  logic                  data_ok_q;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  unused_in;

`ifdef SRAM_RESP_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Size only matters to the master; upper address bits alias.
  assign unused_in = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

  assign idx               = data_sram_addr[DEPTH_LOG2+1:2];
  assign accept            = data_sram_req & ~reset & ~stall & (count < CNT_W'(QDEPTH));
  assign data_sram_addr_ok = accept;

  // Writes commit at accept, so the in-order queue alone gives read-after-write ordering.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  sram_like_resp_fifo #(
    .DEPTH   (QDEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (accept),
    .pop_i        (head_ready),
    .push_is_wr_i (data_sram_wr),
    .push_data_i  (mem[idx]),
    .head_ready_o (head_ready),
    .head_is_wr_o (head_is_wr),
    .head_data_o  (head_data),
    .count_o      (count)
  );

  assign rdata_d = (head_ready && !head_is_wr) ? head_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= head_ready;
      rdata_q   <= rdata_d;
    end
  end

  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

endmodule
